// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-master memory arbiter:
//   - state_t  : arbiter FSM states (IDLE, ACCESS, DONE)
//   - req_id_t : requester identity (instruction fetch / data memory)
//   - default width constants and the wait counter width
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_DATA_W      = 64;
    localparam int DEF_ADDR_W      = 64;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int CNT_W           = 4;   // wait counter width, WAIT_CYCLES 0..15

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// -----------------------------------------------------------------------------
// mem_arb_wait_cnt
// Down-counter that times the ACCESS phase. Loaded on entry to ACCESS,
// decremented each ACCESS cycle, saturates at zero (never wraps).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   load       : load load_val (takes precedence over dec)
//   load_val   : value to load
//   dec        : decrement request, ignored once the count is zero
//   zero       : count equals zero
// -----------------------------------------------------------------------------
module mem_arb_wait_cnt
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs as they were before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port (if_*) and a data port (dm_*) onto one
// shared memory with a fixed access time of WAIT_CYCLES+1 cycles.
//
// Transaction: IDLE samples the requests and latches the winner's id, address,
// write data and write enable; ACCESS drives the shared bus from the latched
// copy for WAIT_CYCLES+1 cycles (write strobe / read capture on the last one);
// DONE pulses the winner's done for one cycle, then back to IDLE.
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN  defined   : a tie goes to the requester that was
//                                       not granted last (dm wins the first)
//                           undefined : dm always wins a tie
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   if_req, if_addr            : fetch request and address
//   if_rdata, if_done          : fetched word (registered), completion pulse
//   dm_req, dm_we, dm_addr,
//   dm_wdata                   : data request, write enable, address, store data
//   dm_rdata, dm_done          : load data (registered), completion pulse
//   mem_a, mem_wd, mem_we      : shared memory address, write data, write strobe
//   mem_rd                     : shared memory combinational read data
//   busy                       : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy
);

    state_t            state;
    state_t            state_next;
    req_id_t           winner;
    req_id_t           lat_id;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              start;
    logic              cnt_zero;
    logic              last_access;

    // A transaction starts only from IDLE; requests in ACCESS/DONE are ignored.
    assign start       = (state == ST_IDLE) && (if_req || dm_req);
    assign last_access = (state == ST_ACCESS) && cnt_zero;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_t last_grant;

    always_comb begin
        if (if_req && dm_req) begin
            winner = (last_grant == REQ_DM) ? REQ_IF : REQ_DM;
        end else if (dm_req) begin
            winner = REQ_DM;
        end else begin
            winner = REQ_IF;
        end
    end

    // Resets to REQ_IF so the data port wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_IF;
        end else if (start) begin
            last_grant <= winner;
        end
    end
`else
    assign winner = dm_req ? REQ_DM : REQ_IF;
`endif

    mem_arb_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .load_val (CNT_W'(WAIT_CYCLES)),
        .dec      (state == ST_ACCESS),
        .zero     (cnt_zero)
    );

    // Snapshot of the granted request; ACCESS never looks at live inputs, so
    // a requester may drop req mid-access without disturbing the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_id    <= REQ_IF;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
        end else if (start) begin
            lat_id <= winner;
            if (winner == REQ_DM) begin
                lat_addr  <= dm_addr;
                lat_wdata <= dm_wdata;
                lat_we    <= dm_we;
            end else begin
                lat_addr  <= if_addr;
                lat_wdata <= '0;
                lat_we    <= 1'b0;       // fetches never write
            end
        end
    end

    // Read data is captured at the end of the last ACCESS cycle into the
    // winner's register only; the other port keeps its previous word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else if (last_access && !lat_we) begin
            if (lat_id == REQ_DM) begin
                dm_rdata <= mem_rd;
            end else begin
                if_rdata <= mem_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode the current state, so an asynchronous reset drops them
    // immediately and an aborted write never strobes or reports done.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves one unassigned (which would infer a latch).
        state_next = state;
        mem_a      = '0;
        mem_wd     = '0;
        mem_we     = 1'b0;
        if_done    = 1'b0;
        dm_done    = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (if_req || dm_req) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_a  = lat_addr;
                mem_wd = lat_wdata;
                if (cnt_zero) begin
                    mem_we     = lat_we;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if_done    = (lat_id == REQ_IF);
                dm_done    = (lat_id == REQ_DM);
                state_next = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. u_dut runs with WAIT_CYCLES=2, u_dut0 with
// WAIT_CYCLES=0; both read from a small word-indexed memory model (mem_a[5:3]).
// Latency is the number of the cycle, counted from the request-sampling edge,
// in which done is high (cycle 1 starts at the sampling edge).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;

    logic        if_req, dm_req, dm_we;
    logic [63:0] if_addr, dm_addr, dm_wdata;
    logic [63:0] if_rdata, dm_rdata, mem_a, mem_wd, mem_rd;
    logic        if_done, dm_done, mem_we, busy;

    logic        d0_dm_req;
    logic [63:0] d0_dm_addr;
    logic [63:0] d0_if_rdata, d0_dm_rdata, d0_mem_a, d0_mem_wd, d0_mem_rd;
    logic        d0_if_done, d0_dm_done, d0_mem_we, d0_busy;
    logic        zero_bit;
    logic [63:0] zero_word;

    logic [63:0] mem_arr [8];

    int          n_cmp;
    int          n_bad;
    int          cyc;

    int          we_cnt, we_cyc, dm_done_cnt, dm_done_cyc, if_done_cnt, both_cnt;
    logic [63:0] we_a, we_d;
    bit          done_log [$];
    int          d0_done_cyc [$];

    assign mem_rd    = mem_arr[mem_a[5:3]];
    assign d0_mem_rd = mem_arr[d0_mem_a[5:3]];

    mem_arbiter #(.DATA_W(64), .ADDR_W(64), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .busy(busy)
    );

    mem_arbiter #(.DATA_W(64), .ADDR_W(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .if_req(zero_bit), .if_addr(zero_word), .if_rdata(d0_if_rdata), .if_done(d0_if_done),
        .dm_req(d0_dm_req), .dm_we(zero_bit), .dm_addr(d0_dm_addr), .dm_wdata(zero_word),
        .dm_rdata(d0_dm_rdata), .dm_done(d0_dm_done),
        .mem_a(d0_mem_a), .mem_wd(d0_mem_wd), .mem_we(d0_mem_we), .mem_rd(d0_mem_rd),
        .busy(d0_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            we_cyc = cyc;
            we_a   = mem_a;
            we_d   = mem_wd;
        end
        if (dm_done) begin
            dm_done_cnt++;
            dm_done_cyc = cyc;
            done_log.push_back(1'b1);
        end
        if (if_done) begin
            if_done_cnt++;
            done_log.push_back(1'b0);
        end
        if (dm_done && if_done) both_cnt++;
        if (d0_dm_done) d0_done_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for the done of one port; drop_first releases that port's req at
    // the first mid-cycle point after sampling (one-cycle request pulse).
    task automatic wait_done(input bit is_dm, input bit drop_first, input int s, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (drop_first && k == 0) begin
                if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
            end
            if (is_dm ? dm_done : if_done) begin
                seen = 1'b1;
                lat  = cyc - s;
                if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
            end
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic access(input bit is_dm, input bit we, input logic [63:0] addr,
                          input logic [63:0] wd, input bit pulse, output int lat);
        int s;
        @(negedge clk);
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        s = cyc;
        wait_done(is_dm, pulse, s, lat);
    endtask

    int          lat, s, n0, w0, d0, i0, lg;
    logic [63:0] if_prev;

    initial begin
        for (int i = 0; i < 8; i++) mem_arr[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        mem_arr[2] = 64'hDEAD_BEEF;
        mem_arr[3] = 64'h3333_0003;
        mem_arr[4] = 64'hCAFE_F00D;
        mem_arr[5] = 64'h5555_0005;
        mem_arr[6] = 64'h6666_0006;
        n_cmp = 0; n_bad = 0; cyc = 0;
        zero_bit = 1'b0; zero_word = '0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        d0_dm_req = 1'b0; d0_dm_addr = '0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_a",  mem_a, 64'd0);
        check("rst_mem_wd", mem_wd, 64'd0);
        check("rst_done",   64'({if_done, dm_done}), 64'd0);
        check("rst_rdata",  if_rdata | dm_rdata, 64'd0);
        check("rst_busy0",  64'(d0_busy), 64'd0);
        rst_n = 1'b1;

        // Read 0x10, WAIT_CYCLES=2
        w0 = we_cnt;
        access(1'b1, 1'b0, 64'h10, 64'd0, 1'b0, lat);
        check("rd_lat", 64'(lat), 64'd4);
        @(posedge clk); #1;
        check("rd_rdata", dm_rdata, 64'hDEAD_BEEF);
        check("rd_no_we", 64'(we_cnt - w0), 64'd0);
        check("rd_busy_after", 64'(busy), 64'd0);

        // Write 0x08 <- 0x1234
        w0 = we_cnt;
        access(1'b1, 1'b1, 64'h08, 64'h1234, 1'b0, lat);
        @(posedge clk); #1;
        check("wr_we_count", 64'(we_cnt - w0), 64'd1);
        check("wr_mem_a",    we_a, 64'h08);
        check("wr_mem_wd",   we_d, 64'h1234);
        check("wr_done_next", 64'(dm_done_cyc - we_cyc), 64'd1);
        check("wr_lat",      64'(lat), 64'd4);
        check("wr_rdata_hold", dm_rdata, 64'hDEAD_BEEF);

        // One-cycle fetch pulse at 0x20
        i0 = if_done_cnt;
        access(1'b0, 1'b0, 64'h20, 64'd0, 1'b1, lat);
        @(posedge clk); #1;
        check("if_lat",   64'(lat), 64'd4);
        check("if_rdata", if_rdata, 64'hCAFE_F00D);
        check("if_dm_hold", dm_rdata, 64'hDEAD_BEEF);
        check("if_done_count", 64'(if_done_cnt - i0), 64'd1);

        // Simultaneous requests held for two transactions
        if_prev = if_rdata;
        n0 = done_log.size();
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h28;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h30;
        for (int k = 0; k < 40 && done_log.size() < n0 + 2; k++) @(posedge clk);
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("tie_count", 64'(done_log.size() - n0), 64'd2);
        if (done_log.size() >= n0 + 2) begin
            check("tie_first", 64'(done_log[n0]), 64'd1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            check("tie_second", 64'(done_log[n0 + 1]), 64'd0);
            check("tie_if_rdata", if_rdata, 64'h5555_0005);
`else
            check("tie_second", 64'(done_log[n0 + 1]), 64'd1);
            check("tie_if_rdata", if_rdata, if_prev);
`endif
        end
        check("tie_dm_rdata", dm_rdata, 64'h6666_0006);
        check("no_double_done", 64'(both_cnt), 64'd0);

        // Reset during the second ACCESS cycle of a write
        w0 = we_cnt; d0 = dm_done_cnt;
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h38; dm_wdata = 64'hBAD;
        @(posedge clk);            // sampling edge
        @(posedge clk); #1;        // now in second ACCESS cycle
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("abort_mem_we", 64'(mem_we), 64'd0);
        check("abort_mem_bus", mem_a | mem_wd, 64'd0);
        check("abort_done", 64'({if_done, dm_done}), 64'd0);
        check("abort_rdata", if_rdata | dm_rdata, 64'd0);
        check("abort_no_we", 64'(we_cnt - w0), 64'd0);
        check("abort_no_done", 64'(dm_done_cnt - d0), 64'd0);
        // Request present as reset releases: no move before the next edge.
        dm_addr = 64'h10; rst_n = 1'b1; dm_req = 1'b1;
        s = cyc;
        #1;
        check("release_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("release_start", 64'(busy), 64'd1);
        wait_done(1'b1, 1'b0, s, lat);
        check("post_rst_lat", 64'(lat), 64'd4);
        @(posedge clk); #1;
        check("post_rst_rdata", dm_rdata, 64'hDEAD_BEEF);

        // WAIT_CYCLES=0, back-to-back reads
        lg = d0_done_cyc.size();
        @(negedge clk);
        d0_dm_req = 1'b1; d0_dm_addr = 64'h18;
        s = cyc;
        for (int k = 0; k < 40 && d0_done_cyc.size() < lg + 2; k++) @(posedge clk);
        @(negedge clk);
        d0_dm_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("w0_count", 64'(d0_done_cyc.size() - lg), 64'd2);
        if (d0_done_cyc.size() >= lg + 2) begin
            check("w0_lat", 64'(d0_done_cyc[lg] - s), 64'd2);
            // DONE, one IDLE cycle, one ACCESS cycle, DONE
            check("w0_gap", 64'(d0_done_cyc[lg + 1] - d0_done_cyc[lg]), 64'd3);
        end
        check("w0_rdata", d0_dm_rdata, 64'h3333_0003);
        check("w0_busy", 64'(d0_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, memory data width.
REQ-002 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, extra memory access cycles (legal 0..15).
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word (registered).
- if_done  out  1  fetch complete (1-cycle pulse).
- dm_req  in  1  data request.
- dm_we  in  1  data write enable.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data (registered).
- dm_done  out  1  data access complete (1-cycle pulse).
- mem_a  out  ADDR_W  shared memory address.
- mem_wd  out  DATA_W  shared memory write data.
- mem_we  out  1  shared memory write strobe.
- mem_rd  in  DATA_W  shared memory combinational read data.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on any sampled request; ACCESS->DONE after WAIT_CYCLES+1 cycles; DONE->IDLE unconditionally.
REQ-006 SHALL, in IDLE, latch winner ID, address, wdata and we (we forced 0 for fetch) at the sampling edge; ACCESS uses only latched values.
REQ-007 SHALL drive mem_a and mem_wd from latched values during ACCESS, and 0 otherwise.
REQ-008 SHALL assert mem_we for exactly one cycle: the final ACCESS cycle of a write.
REQ-009 SHALL capture mem_rd into the winner's rdata register at the end of the final ACCESS cycle (reads only); the other rdata register holds its value.
REQ-010 SHALL pulse the winner's done in DONE; done latency = WAIT_CYCLES+2 cycles after the request-sampling edge.
REQ-011 SHALL ignore requests while in ACCESS or DONE; a req still high in IDLE starts a new transaction (requester deasserts req on the edge after done).
REQ-012 SHALL complete an in-flight transaction even if its req drops mid-access.
REQ-013 SHALL grant dm over if on simultaneous requests (fixed priority) unless REQ-018 applies.
REQ-014 SHALL use a 4-bit wait counter loaded with WAIT_CYCLES on IDLE->ACCESS and decremented to 0; no wrap.

Reset
REQ-015 SHALL, on rst_n low, asynchronously force state IDLE, counter 0, mem_we/if_done/dm_done/busy 0, mem_a/mem_wd 0, if_rdata/dm_rdata 0.
REQ-016 SHALL, on reset mid-ACCESS, abort the transaction with no write and no done pulse.
REQ-017 SHALL leave IDLE no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-018 SHALL, with MEM_ARB_ROUND_ROBIN_EN defined, resolve simultaneous requests to the requester not granted last (last-grant register resets to "if", so dm wins first tie); without it, fixed dm priority and no last-grant register.

Structure
REQ-019 SHALL place the state enum, requester-ID enum (REQ_IF, REQ_DM) and default width constants in package mem_arb_pkg.
REQ-020 SHALL implement the wait counter as sub-module mem_arb_wait_cnt (load, decrement, zero flag).

Verification
REQ-021 Read dm_addr=0x10, mem_rd=0xDEADBEEF, WAIT_CYCLES=2 -> dm_done 4 cycles after sampling, dm_rdata=0xDEADBEEF, mem_we never high.
REQ-022 Write dm_addr=0x08, dm_wdata=0x1234 -> mem_we high exactly one cycle with mem_a=0x08, mem_wd=0x1234; dm_done next cycle.
REQ-023 if_req and dm_req together for 2 transactions -> fixed: dm,dm; MEM_ARB_ROUND_ROBIN_EN: dm then if.
REQ-024 if_req pulsed 1 cycle, addr 0x20 -> fetch completes, if_done pulses, if_rdata = mem_rd, dm_rdata unchanged.
REQ-025 rst_n low during write's second ACCESS cycle -> mem_we never asserted, no done, all outputs 0, busy 0.
REQ-026 WAIT_CYCLES=0 back-to-back reads -> done latency 2 cycles, one IDLE cycle between transactions.
